// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with load, cascade carry and sticky wrap flag.
// Optional registered Gray-code output when COUNTER_GRAY_OUT_EN is defined.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc_out,
    output logic             wrapped
`ifdef COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("mod_n_updown_counter: WIDTH must be 2..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_n_updown_counter: MODULUS must be 2..2**WIDTH");
        end
`ifdef COUNTER_GRAY_OUT_EN
        if (MODULUS != (1 << WIDTH)) begin : g_bad_gray
            $error("mod_n_updown_counter: Gray output needs MODULUS == 2**WIDTH");
        end
`endif
    endgenerate

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    always_comb begin
        q_next    = q;
        wrap_next = wrapped;
        if (load) begin
            q_next    = ({1'b0, d} >= MOD_EXT) ? QMAX : d;
            wrap_next = 1'b0;
        end else if (en) begin
            if (up) begin
                // >= also catches a corrupted out-of-range count and treats it as a wrap
                if (q >= QMAX) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
                    q_next    = QMAX;
                    wrap_next = 1'b1;
                end else if (q > QMAX) begin
                    q_next = QMAX;
                end else begin
                    q_next = q - 1'b1;
                end
            end
        end
    end

    assign tc_out = clear & en & ~load & (up ? (q == QMAX) : (q == '0));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q       <= '0;
            wrapped <= 1'b0;
        end else begin
            q       <= q_next;
            wrapped <= wrap_next;
        end
    end

`ifdef COUNTER_GRAY_OUT_EN
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            gray <= '0;
        end else begin
            gray <= q_next ^ (q_next >> 1);
        end
    end
`endif

endmodule
